spi_minion_core: RTL and testbench

SPI_MINION_CORE -- requirements
Module: spi_minion_core

---
 rtl/spi_minion_core_pkg.sv | 24 ++
 rtl/spi_minion_core_sync.sv | 33 +++
 rtl/spi_minion_core.sv | 106 ++++++++++
 tb/tb_spi_minion_core.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/spi_minion_core_pkg.sv
// Shared SPI frame layout constants and helpers for the minion core.
// Field positions scale with the frame width, so they are exposed as constant functions.
package spi_minion_core_pkg;

    localparam int NBITS_DEFAULT = 8;
    localparam int SYNC_STAGES   = 2;

    function automatic int val_bit(input int nbits);
        return nbits - 1;
    endfunction

    function automatic int spc_bit(input int nbits);
        return nbits - 2;
    endfunction

    function automatic int data_w(input int nbits);
        return nbits - 2;
    endfunction

    function automatic int cnt_w(input int nbits);
        return $clog2(nbits + 2);
    endfunction

endpackage

// File: rtl/spi_minion_core_sync.sv
// Two-flop synchronizer plus one history flop for rise/fall detection
// of an asynchronous SPI pin.
module spi_sync_edge
    import spi_minion_core_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] meta;
    logic                   hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= {SYNC_STAGES{RST_VAL}};
            hist <= RST_VAL;
        end else begin
            meta <= {meta[SYNC_STAGES-2:0], din};
            hist <= meta[SYNC_STAGES-1];
        end
    end

    assign sync = meta[SYNC_STAGES-1];
    assign rise = meta[SYNC_STAGES-1] & ~hist;
    assign fall = ~meta[SYNC_STAGES-1] & hist;

endmodule

// File: rtl/spi_minion_core.sv
// SPI mode-0 minion: loads an outgoing frame on cs fall, shifts it out on miso,
// and pushes the received frame on cs rise when exactly nbits were clocked.
module spi_minion_core
    import spi_minion_core_pkg::*;
#(
    parameter int nbits = NBITS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cs,
    input  logic                     sclk,
    input  logic                     mosi,
    output logic                     miso,
    output logic                     pull_en,
    input  logic                     pull_msg_val,
    input  logic                     pull_msg_spc,
    input  logic [data_w(nbits)-1:0] pull_msg_data,
    output logic                     push_en,
    output logic                     push_msg_val_wrt,
    output logic                     push_msg_val_rd,
    output logic [data_w(nbits)-1:0] push_msg_data
);

    localparam int VB = val_bit(nbits);
    localparam int SB = spc_bit(nbits);
    localparam int CW = cnt_w(nbits);

    logic cs_sync, cs_rise, cs_fall;
    logic sclk_sync, sclk_rise, sclk_fall;
    logic mosi_sync, mosi_rise, mosi_fall;
    logic unused_edges;

    spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
        .clk(clk), .reset(reset), .din(cs),
        .sync(cs_sync), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
        .clk(clk), .reset(reset), .din(sclk),
        .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
        .clk(clk), .reset(reset), .din(mosi),
        .sync(mosi_sync), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_edges = ^{sclk_sync, mosi_rise, mosi_fall};

    logic [nbits-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             sample;
    logic             active;
    logic             armed;
    logic [1:0]       vld_pipe;

    // cs_sync only reflects the real pin once the synchronizer has refilled after
    // reset; arming waits for that so a cs held low through reset never pulls.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg            <= '0;
            cnt              <= '0;
            sample           <= 1'b0;
            active           <= 1'b0;
            armed            <= 1'b0;
            vld_pipe         <= '0;
            pull_en          <= 1'b0;
            push_en          <= 1'b0;
            push_msg_val_wrt <= 1'b0;
            push_msg_val_rd  <= 1'b0;
            push_msg_data    <= '0;
        end else begin
            pull_en  <= 1'b0;
            push_en  <= 1'b0;
            vld_pipe <= {vld_pipe[0], 1'b1};
            if (vld_pipe[1] && cs_sync)
                armed <= 1'b1;

            if (cs_fall && armed) begin
                pull_en <= 1'b1;
                shreg   <= {pull_msg_val, pull_msg_spc, pull_msg_data};
                cnt     <= '0;
                active  <= 1'b1;
            end else if (cs_rise) begin
                active <= 1'b0;
                if (active && cnt == CW'(nbits)) begin
                    push_en <= 1'b1;
                    {push_msg_val_wrt, push_msg_val_rd, push_msg_data} <= {shreg[SB:0], sample};
                end
            end else if (active) begin
                if (sclk_rise) begin
                    sample <= mosi_sync;
                    if (cnt != CW'(nbits + 1))
                        cnt <= cnt + CW'(1);
                end else if (sclk_fall && cnt < CW'(nbits)) begin
                    // The trailing fall after the last bit must not shift, or the
                    // pushed frame {shreg[nbits-2:0], sample} would double the last bit.
                    shreg <= {shreg[SB:0], sample};
                end
            end
        end
    end

    assign miso = active & shreg[VB];

endmodule

// File: tb/tb_spi_minion_core.sv
// Randomized SPI host driving the minion, checked against a frame-level model
// (expected push queue, expected miso bits per frame).
module tb_spi_minion_core;

    localparam int NB = 8;
    localparam int PH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cs = 1'b1;
    logic          sclk = 1'b0;
    logic          mosi = 1'b0;
    logic          miso;
    logic          pull_en;
    logic          pull_msg_val = 1'b0;
    logic          pull_msg_spc = 1'b0;
    logic [NB-3:0] pull_msg_data = '0;
    logic          push_en;
    logic          push_msg_val_wrt;
    logic          push_msg_val_rd;
    logic [NB-3:0] push_msg_data;

    spi_minion_core #(.nbits(NB)) dut (
        .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
        .pull_en(pull_en), .pull_msg_val(pull_msg_val), .pull_msg_spc(pull_msg_spc),
        .pull_msg_data(pull_msg_data), .push_en(push_en),
        .push_msg_val_wrt(push_msg_val_wrt), .push_msg_val_rd(push_msg_val_rd),
        .push_msg_data(push_msg_data)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_tot = 0;
    int pull_cnt = 0, push_cnt = 0, exp_pull = 0, exp_push = 0;
    logic [NB-1:0] exp_q[$];
    logic [NB-1:0] last_push = '0;
    logic [NB-1:0] miso_seen = '0;
    logic          mon_on = 1'b0;
    logic          rst_q = 1'b0;
    int            cs_hi = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        rst_q <= reset;
        cs_hi <= cs ? cs_hi + 1 : 0;
    end

    // Per-cycle compare against the frame-level model.
    always @(negedge clk) begin
        logic [NB-1:0] got;
        if (mon_on) begin
            got = {push_msg_val_wrt, push_msg_val_rd, push_msg_data};
            check("pull_push_exclusive", pull_en & push_en, 0);
            if (pull_en) pull_cnt++;
            if (rst_q) begin
                check("reset_quiet", {pull_en, push_en, miso, got}, 0);
                last_push = '0;
            end else if (push_en) begin
                push_cnt++;
                check("push_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("push_frame", got, exp_q.pop_front());
                last_push = got;
            end else begin
                check("push_hold", got, last_push);
            end
            if (cs_hi >= 4) check("miso_idle", miso, 0);
        end
    end

    task automatic frame(input int pulses, input logic [NB-1:0] tx, input logic [NB-1:0] rx,
                         input int rst_at, input int gap);
        int p0;
        bit aborted;
        p0 = pull_cnt;
        aborted = 0;
        {pull_msg_val, pull_msg_spc, pull_msg_data} = tx;
        exp_pull++;
        if (pulses == NB && rst_at < 0) begin
            exp_q.push_back(rx);
            exp_push++;
        end
        cs = 1'b0;
        wait_clk(PH);
        check("pull_once", pull_cnt, p0 + 1);
        for (int i = 0; i < pulses; i++) begin
            mosi = (i < NB) ? rx[NB-1-i] : 1'($urandom_range(0, 1));
            wait_clk(PH);
            if (i < NB && !aborted) begin
                miso_seen[NB-1-i] = miso;
                check("miso_bit", miso, tx[NB-1-i]);
            end
            sclk = 1'b1;
            wait_clk(PH);
            sclk = 1'b0;
            if (i == rst_at) begin
                reset = 1'b1;
                wait_clk(2);
                reset = 1'b0;
                wait_clk(1);
                check("abort_miso", miso, 0);
                aborted = 1;
            end
        end
        wait_clk(PH);
        cs = 1'b1;
        wait_clk(gap);
    endtask

    initial begin
        int p0, q0;
        repeat (4) @(posedge clk);
        #1;
        mon_on = 1'b1;
        check("rst_miso", miso, 0);
        check("rst_pull_en", pull_en, 0);
        check("rst_push_en", push_en, 0);
        check("rst_push_msg", {push_msg_val_wrt, push_msg_val_rd, push_msg_data}, 0);
        reset = 1'b0;
        wait_clk(6);

        // Fixed frame with hand-computed results.
        frame(NB, {1'b1, 1'b1, 6'h2A}, 8'b10_010101, -1, 10);
        check("t1_miso_bits", miso_seen, 8'hEA);
        check("t1_val_wrt", push_msg_val_wrt, 1);
        check("t1_val_rd", push_msg_val_rd, 0);
        check("t1_data", push_msg_data, 6'h15);
        check("t1_pushes", push_cnt, 1);

        // Short frame, then a full one.
        q0 = push_cnt;
        frame(NB - 1, 8'h5C, 8'hA3, -1, 10);
        check("short_no_push", push_cnt, q0);
        frame(NB, 8'h3D, 8'hC6, -1, 10);
        check("after_short_push", push_cnt, q0 + 1);

        // Long frame.
        q0 = push_cnt;
        frame(NB + 1, 8'h81, 8'h7E, -1, 10);
        check("long_no_push", push_cnt, q0);

        // Back-to-back with minimal cs-high gap.
        p0 = pull_cnt;
        q0 = push_cnt;
        frame(NB, 8'hB4, 8'h1F, -1, 4);
        frame(NB, 8'h4B, 8'hE0, -1, 10);
        check("b2b_pulls", pull_cnt, p0 + 2);
        check("b2b_pushes", push_cnt, q0 + 2);

        // Reset after bit 4 aborts the frame.
        q0 = push_cnt;
        frame(NB, 8'hFF, 8'h99, 4, 10);
        check("reset_no_push", push_cnt, q0);
        frame(NB, 8'h96, 8'h69, -1, 10);
        check("after_reset_push", push_cnt, q0 + 1);

        // sclk toggling while deselected.
        p0 = pull_cnt;
        q0 = push_cnt;
        repeat (10) begin
            sclk = 1'b1;
            wait_clk(PH);
            sclk = 1'b0;
            wait_clk(PH);
        end
        check("idle_sclk_no_pull", pull_cnt, p0);
        check("idle_sclk_no_push", push_cnt, q0);
        frame(NB, 8'h27, 8'hD2, -1, 10);

        // Randomized frames.
        for (int k = 0; k < 20; k++) begin
            int r, np;
            r = int'($urandom_range(0, 5));
            np = (r == 0) ? NB - 1 : (r == 1) ? NB + 1 : NB;
            frame(np, NB'($urandom), NB'($urandom), -1, int'($urandom_range(4, 12)));
        end
        wait_clk(10);

        check("final_queue_empty", exp_q.size(), 0);
        check("final_pulls", pull_cnt, exp_pull);
        check("final_pushes", push_cnt, exp_push);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
